// File: rtl/mmio_uart_tx_queue.sv
// Memory-mapped 8N1 UART transmitter fed from a 256-byte ring buffer.
// Software writes bytes into the buffer, then advances tail; hardware drains from head to tail.
module mmio_uart_tx_queue #(
  parameter int CLK_FREQ  = 27000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  output logic        uart_tx,
  input  logic        input_cmd_start,
  input  logic        input_cmd_write,
  output logic        output_cmd_ready,
  input  logic [31:0] input_addr,
  output logic [31:0] output_rdata,
  output logic        output_rdata_valid,
  input  logic [31:0] input_wdata
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  logic [31:0] r_mem [0:63];
  logic [7:0]  r_head;
  logic [7:0]  r_tail;
  logic [31:0] r_rdata;
  logic        r_rdata_valid;

  tx_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shreg;
  logic        r_tx;

  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic        w_sel_buf;
  logic        w_sel_tail;
  logic        w_sel_head;
  logic [31:0] w_rdata_next;
  logic [31:0] w_head_word;
  logic [7:0]  w_head_byte;

  tx_state_t   w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]  w_bit_next;
  logic [7:0]  w_shreg_next;
  logic        w_tx_next;
  logic        w_head_inc;
  logic        w_cnt_done;

  // A read blocks the following cycle, so ready is simply the inverse of the valid pulse.
  assign output_cmd_ready   = ~r_rdata_valid;
  assign output_rdata       = r_rdata;
  assign output_rdata_valid = r_rdata_valid;
  assign uart_tx            = r_tx;

  assign w_accept   = input_cmd_start & output_cmd_ready;
  assign w_wr       = w_accept & input_cmd_write;
  assign w_rd       = w_accept & ~input_cmd_write;
  assign w_sel_buf  = (input_addr[31:9] == 23'd0) & ~input_addr[8];
  assign w_sel_tail = (input_addr == 32'h0000_0100);
  assign w_sel_head = (input_addr == 32'h0000_0104);

  // NOTE: the buffer RAM carries no reset so it maps onto plain memory; software always writes before use.
  always_ff @(posedge clk) begin
    if (w_wr && w_sel_buf) r_mem[input_addr[7:2]] <= input_wdata;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rdata_next = '0;
    if (w_sel_buf)       w_rdata_next = r_mem[input_addr[7:2]];
    else if (w_sel_tail) w_rdata_next = {24'd0, r_tail};
    else if (w_sel_head) w_rdata_next = {24'd0, r_head};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= w_rd;
      if (w_rd) r_rdata <= w_rdata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tail <= '0;
      r_head <= '0;
    end else begin
      if (w_wr && w_sel_tail) r_tail <= input_wdata[7:0];
      if (w_head_inc)         r_head <= r_head + 8'd1;
    end
  end

  assign w_head_word = r_mem[r_head[7:2]];
  assign w_head_byte = w_head_word[{r_head[1:0], 3'b000} +: 8];
  assign w_cnt_done  = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shreg <= w_shreg_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_cnt_done ? '0 : r_cnt + 1'b1;
    w_bit_next   = r_bit;
    w_shreg_next = r_shreg;
    w_head_inc   = 1'b0;
    w_tx_next    = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (r_head != r_tail) begin
          w_shreg_next = w_head_byte;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_cnt_done) begin
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_cnt_done) begin
          if (r_bit == 3'd7) w_state_next = S_STOP;
          else               w_bit_next   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (w_cnt_done) begin
          w_head_inc   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Line level is registered from the next state so uart_tx is glitch-free and aligned with r_state.
    unique case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shreg_next[w_bit_next];
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx_queue.sv
// Directed bench for mmio_uart_tx_queue at 10 clocks per bit: bus access, framing, wrap, reset abort.
module tb_mmio_uart_tx_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_tx;
  logic        input_cmd_start;
  logic        input_cmd_write;
  logic        output_cmd_ready;
  logic [31:0] input_addr;
  logic [31:0] output_rdata;
  logic        output_rdata_valid;
  logic [31:0] input_wdata;

  int n_checks = 0;
  int n_errors = 0;

  mmio_uart_tx_queue #(.CLK_FREQ(10), .BAUD_RATE(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .uart_tx            (uart_tx),
    .input_cmd_start    (input_cmd_start),
    .input_cmd_write    (input_cmd_write),
    .output_cmd_ready   (output_cmd_ready),
    .input_addr         (input_addr),
    .output_rdata       (output_rdata),
    .output_rdata_valid (output_rdata_valid),
    .input_wdata        (input_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (output_cmd_ready === 1'b1) break;
      tick();
    end
    if (output_cmd_ready !== 1'b1) check("ready_timeout", 32'(output_cmd_ready), 32'd1);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wait_ready();
    input_cmd_start = 1'b1;
    input_cmd_write = 1'b1;
    input_addr      = a;
    input_wdata     = d;
    tick();
    input_cmd_start = 1'b0;
    input_cmd_write = 1'b0;
  endtask

  // Checks the one-cycle valid pulse and the single ready bubble around every read.
  task automatic bus_read(input string tag, input logic [31:0] a, output logic [31:0] d);
    wait_ready();
    input_cmd_start = 1'b1;
    input_cmd_write = 1'b0;
    input_addr      = a;
    tick();
    input_cmd_start = 1'b0;
    check({tag, "_valid"}, 32'(output_rdata_valid), 32'd1);
    check({tag, "_busy"}, 32'(output_cmd_ready), 32'd0);
    d = output_rdata;
    tick();
    check({tag, "_vdrop"}, 32'(output_rdata_valid), 32'd0);
    check({tag, "_rdy"}, 32'(output_cmd_ready), 32'd1);
  endtask

  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(tag, a, d);
    check(tag, d, exp);
  endtask

  task automatic expect_idle(input string tag, input int n);
    int lows = 0;
    repeat (n) begin
      if (uart_tx !== 1'b1) lows++;
      tick();
    end
    check(tag, 32'(lows), 32'd0);
  endtask

  // Waits for a start bit, then compares every one of the 100 frame cycles against the ideal waveform.
  task automatic expect_frame(input string tag, input logic [7:0] exp, output int gap);
    int   waited = 0;
    int   bad = 0;
    int   bit_i;
    logic e;
    logic [7:0] got = '0;
    while (uart_tx !== 1'b0 && waited < 400) begin
      tick();
      waited++;
    end
    gap = waited;
    if (uart_tx !== 1'b0) begin
      check({tag, "_start"}, 32'(uart_tx), 32'd0);
      return;
    end
    for (int i = 0; i < 100; i++) begin
      bit_i = i / 10;
      if (bit_i == 0)      e = 1'b0;
      else if (bit_i == 9) e = 1'b1;
      else                 e = exp[bit_i-1];
      if (uart_tx !== e) bad++;
      if ((i % 10) == 5 && bit_i >= 1 && bit_i <= 8) got[bit_i-1] = uart_tx;
      tick();
    end
    check({tag, "_byte"}, 32'(got), 32'(exp));
    check({tag, "_shape"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int          gap;
    int          polls;
    logic [31:0] d;

    rst             = 1'b1;
    input_cmd_start = 1'b0;
    input_cmd_write = 1'b0;
    input_addr      = '0;
    input_wdata     = '0;
    repeat (3) tick();
    rst = 1'b0;

    // 1: reset state, index reads, quiet line
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_ready", 32'(output_cmd_ready), 32'd1);
    check("rst_valid", 32'(output_rdata_valid), 32'd0);
    check("rst_rdata", output_rdata, 32'd0);
    read_expect("t1_tail", 32'h100, 32'd0);
    read_expect("t1_head", 32'h104, 32'd0);
    expect_idle("t1_idle", 200);

    // 2: two bytes from one word
    bus_write(32'h000, 32'h4443_4241);
    bus_write(32'h100, 32'd2);
    expect_frame("t2_f0", 8'h41, gap);
    check("t2_latency", 32'(gap), 32'd1);
    expect_frame("t2_f1", 8'h42, gap);
    check("t2_gap", 32'(gap), 32'd1);
    read_expect("t2_head", 32'h104, 32'd2);
    expect_idle("t2_idle", 50);

    // 3: drain to 0xFE, then send across the wrap
    bus_write(32'h100, 32'h0000_00FE);
    polls = 0;
    d = '0;
    while (polls < 200) begin
      bus_read("t3_poll", 32'h104, d);
      if (d == 32'h0000_00FE) break;
      repeat (200) tick();
      polls++;
    end
    check("t3_drained", d, 32'h0000_00FE);
    bus_write(32'h0FC, 32'h3322_1100);
    bus_write(32'h000, 32'h0000_0055);
    bus_write(32'h100, 32'h0000_0001);
    expect_frame("t3_f0", 8'h22, gap);
    expect_frame("t3_f1", 8'h33, gap);
    check("t3_gap", 32'(gap), 32'd1);
    expect_frame("t3_f2", 8'h55, gap);
    read_expect("t3_head", 32'h104, 32'd1);

    // 4: unmapped reads, ignored writes, buffer readback with addr[1:0] ignored
    read_expect("t4_r108", 32'h108, 32'd0);
    read_expect("t4_r200", 32'h200, 32'd0);
    bus_write(32'h104, 32'h0000_0077);
    bus_write(32'h108, 32'h0000_0077);
    read_expect("t4_head", 32'h104, 32'd1);
    read_expect("t4_tail", 32'h100, 32'd1);
    read_expect("t4_buf0", 32'h000, 32'h0000_0055);
    read_expect("t4_bufFE", 32'h0FE, 32'h3322_1100);

    // 5: reset during data bit 3 of 0xA5 (bit 3 is 0)
    bus_write(32'h000, 32'h0000_A555);
    bus_write(32'h100, 32'd2);
    polls = 0;
    while (uart_tx !== 1'b0 && polls < 400) begin
      tick();
      polls++;
    end
    check("t5_start", 32'(uart_tx), 32'd0);
    repeat (45) tick();
    check("t5_bit3", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_tx", 32'(uart_tx), 32'd1);
    check("t5_rdata", output_rdata, 32'd0);
    check("t5_ready", 32'(output_cmd_ready), 32'd1);
    read_expect("t5_head", 32'h104, 32'd0);
    read_expect("t5_tail", 32'h100, 32'd0);
    expect_idle("t5_idle", 200);

    // 6: truncate the queue mid-frame; head still names the in-flight byte until its stop bit ends,
    //    so tail is set to the head value the frame will leave behind
    bus_write(32'h100, 32'd2);
    fork
      expect_frame("t6_f0", 8'h55, gap);
      begin
        repeat (20) tick();
        bus_write(32'h100, 32'd1);
      end
    join
    check("t6_latency", 32'(gap), 32'd1);
    expect_idle("t6_idle", 150);
    read_expect("t6_head", 32'h104, 32'd1);
    read_expect("t6_tail", 32'h100, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
